pla_sweep_driver: RTL

//  Stimulus/response engine for PLA hardware bring-up: drives the 16 PLA input

---
 rtl/pla_sweep_driver_pkg.sv | 23 ++
 rtl/pla_sweep_driver_sync.sv | 26 ++
 rtl/pla_sweep_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pla_sweep_driver_pkg.sv
// Shared definitions for the PLA sweep driver: pin indices, widths and FSM encoding.
// The pin indices are also used by PLA models and benches.
package pla_sweep_driver_pkg;

   localparam int PLA_I_W = 16;
   localparam int PLA_F_W = 8;

   localparam int PLA_I_N_CAS    = 0;
   localparam int PLA_I_N_LORAM  = 1;
   localparam int PLA_I_VA12     = 15;
   localparam int PLA_F_N_CASRAM = 0;
   localparam int PLA_F_N_IO     = 5;
   localparam int PLA_F_N_ROMH   = 7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRIVE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/pla_sweep_driver_sync.sv
// Two-flop synchronizer bringing the asynchronous PLA outputs into the clk domain.
module pla_sweep_driver_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_meta <= '0;
         r_q    <= '0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pla_sweep_driver.sv
// Walks every PLA input vector, compares synchronized outputs with an expected table,
// and reports the mismatch count plus the first failing vector.
module pla_sweep_driver
   import pla_sweep_driver_pkg::*;
#(
   parameter int          SETTLE_CYCLES = 4,
   parameter logic [15:0] LAST_VEC      = 16'hFFFF
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        start,
   input  logic        abort,
   output logic [15:0] pla_i,
   input  logic [7:0]  pla_f,
   output logic [15:0] exp_addr,
   output logic        exp_rd,
   input  logic        exp_valid,
   input  logic [7:0]  exp_data,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [16:0] err_count,
   output logic [15:0] fail_vec,
   output logic [7:0]  fail_got,
   output logic [7:0]  fail_exp,
   output logic [2:0]  o_dbg_state
);

   localparam logic [16:0] ERR_MAX = 17'h10000;

   state_t      r_state;
   logic [15:0] r_vec;
   logic [7:0]  r_cnt;
   logic        r_captured;
   logic [7:0]  r_exp;
   logic [15:0] r_pla_i;
   logic [15:0] r_exp_addr;
   logic        r_exp_rd;
   logic        r_done;
   logic [16:0] r_err;
   logic [15:0] r_fail_vec;
   logic [7:0]  r_fail_got;
   logic [7:0]  r_fail_exp;

   logic [7:0]  w_f_sync;
   logic        w_mismatch;

   pla_sweep_driver_sync #(.W(PLA_F_W)) u_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .i_d     (pla_f),
      .o_q     (w_f_sync)
   );

   assign w_mismatch = (w_f_sync != r_exp);

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_state    <= ST_IDLE;
         r_vec      <= '0;
         r_cnt      <= '0;
         r_captured <= 1'b0;
         r_exp      <= '0;
         r_pla_i    <= '0;
         r_exp_addr <= '0;
         r_exp_rd   <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= '0;
         r_fail_vec <= '0;
         r_fail_got <= '0;
         r_fail_exp <= '0;
      end else if (abort) begin
         // pla_i and the result registers are deliberately left untouched
         r_state    <= ST_IDLE;
         r_exp_rd   <= 1'b0;
         r_done     <= 1'b0;
         r_captured <= 1'b0;
      end else begin
         if (r_exp_rd && exp_valid && !r_captured) begin
            r_exp      <= exp_data;
            r_captured <= 1'b1;
            r_exp_rd   <= 1'b0;
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_vec      <= '0;
                  r_err      <= '0;
                  r_fail_vec <= '0;
                  r_fail_got <= '0;
                  r_fail_exp <= '0;
                  r_done     <= 1'b0;
                  r_state    <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               r_pla_i    <= r_vec;
               r_exp_addr <= r_vec;
               r_exp_rd   <= 1'b1;
               r_captured <= 1'b0;
               r_cnt      <= 8'(SETTLE_CYCLES - 1);
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
               if (r_cnt == 8'd0 && r_captured) r_state <= ST_COMPARE;
            end
            ST_COMPARE: begin
               if (w_mismatch) begin
                  if (r_err == 17'd0) begin
                     r_fail_vec <= r_vec;
                     r_fail_got <= w_f_sync;
                     r_fail_exp <= r_exp;
                  end
                  if (r_err != ERR_MAX) r_err <= r_err + 17'd1;
               end
               if (r_vec == LAST_VEC) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_vec   <= r_vec + 16'd1;
                  r_state <= ST_DRIVE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign pla_i       = r_pla_i;
   assign exp_addr    = r_exp_addr;
   assign exp_rd      = r_exp_rd;
   assign busy        = (r_state == ST_DRIVE) || (r_state == ST_WAIT) || (r_state == ST_COMPARE);
   assign done        = r_done;
   assign pass        = r_done && (r_err == 17'd0);
   assign err_count   = r_err;
   assign fail_vec    = r_fail_vec;
   assign fail_got    = r_fail_got;
   assign fail_exp    = r_fail_exp;
   assign o_dbg_state = r_state;

endmodule
